dwt97_column_sequencer: RTL and testbench

- Frame sequencer placed in front of the column 9/7 DWT stage.
- Accepts a per-frame geometry command (width in pairs, height in lines) and an unframed stream of {odd, even} sample pairs.
- Tags each pair with sof/eol and forwards it to the column filter.
- Optionally appends a dummy flush frame so the filter's line-delay pipeline drains the last real lines.

---
 rtl/dwt97_seq_pkg.sv | 26 ++
 rtl/dwt97_line_counter.sv | 39 +++
 rtl/dwt97_column_sequencer.sv | 143 ++++++++++++++
 tb/tb_dwt97_column_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dwt97_seq_pkg.sv
// Shared types and helpers for the 9/7 DWT column sequencer.
// Widths and command legality are derived from the maximum tile side.
package dwt97_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH
    } state_t;

    function automatic int calc_ww(input int max_side);
        return $clog2(max_side / 2 + 1);
    endfunction

    function automatic int calc_hw(input int max_side);
        return $clog2(max_side + 1);
    endfunction

    // A frame needs at least one pair per line and two lines for the column filter.
    function automatic logic cfg_legal(input int width, input int height,
                                       input int max_side);
        return (width != 0) && (height >= 2) &&
               (width <= max_side / 2) && (height <= max_side);
    endfunction

endpackage

// File: rtl/dwt97_line_counter.sv
// Column/row position counter with wrap at line end and frame end.
// Shared by the real-frame and flush-frame phases of the sequencer.
module dwt97_line_counter #(
    parameter int WW = 9,
    parameter int HW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          advance,
    input  logic [WW-1:0] width,
    input  logic [HW-1:0] height,
    output logic [WW-1:0] col,
    output logic [HW-1:0] row,
    output logic          last_col,
    output logic          last_row
);

    assign last_col = (col == width - WW'(1));
    assign last_row = (row == height - HW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (advance) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + HW'(1);
            end else begin
                col <= col + WW'(1);
            end
        end
    end

endmodule

// File: rtl/dwt97_column_sequencer.sv
// Frame sequencer ahead of the column 9/7 DWT: tags pairs with sof/eol.
// Define DWT97_SEQ_FLUSH_EN to append a zero-data flush frame after each frame.
module dwt97_column_sequencer
    import dwt97_seq_pkg::*;
#(
    parameter int DataWidth       = 16,
    parameter int MaximumSideSize = 512,
    parameter int FlushLines      = 8,
    localparam int WW = calc_ww(MaximumSideSize),
    localparam int HW = calc_hw(MaximumSideSize)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   cfg_valid_i,
    output logic                   cfg_ready_o,
    input  logic [WW-1:0]          cfg_width_i,
    input  logic [HW-1:0]          cfg_height_i,
    output logic                   s_ready_o,
    input  logic                   s_valid_i,
    input  logic [2*DataWidth-1:0] s_data_i,
    input  logic                   m_ready_i,
    output logic                   m_valid_o,
    output logic                   m_sof_o,
    output logic                   m_eol_o,
    output logic [2*DataWidth-1:0] m_data_o,
    output logic                   busy_o,
    output logic                   frame_done_o,
    output logic                   cfg_err_o
);

    state_t        state;
    logic [WW-1:0] width_q;
    logic [HW-1:0] height_q;
    logic [HW-1:0] row_limit;
    logic [WW-1:0] col;
    logic [HW-1:0] row;
    logic          last_col;
    logic          last_row;
    logic          hs;
    logic          last_beat;
    logic          legal;

`ifdef DWT97_SEQ_FLUSH_EN
    assign row_limit = (state == FLUSH) ? HW'(FlushLines) : height_q;
`else
    assign row_limit = height_q;
`endif

    assign legal     = cfg_legal(int'(cfg_width_i), int'(cfg_height_i),
                                 MaximumSideSize);
    assign hs        = m_valid_o & m_ready_i;
    assign last_beat = hs & last_col & last_row;
    assign busy_o    = (state != IDLE);

    dwt97_line_counter #(
        .WW(WW),
        .HW(HW)
    ) u_cnt (
        .clk      (clk_i),
        .rst      (rst_i),
        .clear    (state == IDLE),
        .advance  (hs),
        .width    (width_q),
        .height   (row_limit),
        .col      (col),
        .row      (row),
        .last_col (last_col),
        .last_row (last_row)
    );

    always_comb begin
        cfg_ready_o = 1'b0;
        s_ready_o   = 1'b0;
        m_valid_o   = 1'b0;
        m_sof_o     = 1'b0;
        m_eol_o     = 1'b0;
        m_data_o    = '0;
        unique case (state)
            IDLE: cfg_ready_o = 1'b1;
            STREAM: begin
                m_valid_o = s_valid_i;
                s_ready_o = m_ready_i;
                m_data_o  = s_data_i;
                m_sof_o   = (col == '0) && (row == '0);
                m_eol_o   = last_col;
            end
`ifdef DWT97_SEQ_FLUSH_EN
            FLUSH: begin
                m_valid_o = 1'b1;
                m_sof_o   = (col == '0) && (row == '0);
                m_eol_o   = last_col;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            width_q      <= '0;
            height_q     <= '0;
            frame_done_o <= 1'b0;
            cfg_err_o    <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            cfg_err_o    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cfg_valid_i) begin
                        if (legal) begin
                            width_q  <= cfg_width_i;
                            height_q <= cfg_height_i;
                            state    <= STREAM;
                        end else begin
                            cfg_err_o <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (last_beat) begin
`ifdef DWT97_SEQ_FLUSH_EN
                        state <= FLUSH;
`else
                        state        <= IDLE;
                        frame_done_o <= 1'b1;
`endif
                    end
                end
`ifdef DWT97_SEQ_FLUSH_EN
                FLUSH: begin
                    if (last_beat) begin
                        state        <= IDLE;
                        frame_done_o <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dwt97_column_sequencer.sv
// Directed bench for dwt97_column_sequencer; expects flush frames when
// DWT97_SEQ_FLUSH_EN is defined for both bench and design.
module tb_dwt97_column_sequencer;

    localparam int DW = 16;
    localparam int WW = 9;
    localparam int HW = 10;
    localparam int FL = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [WW-1:0] cfg_width = '0;
    logic [HW-1:0] cfg_height = '0;
    logic          s_ready;
    logic          s_valid = 1'b0;
    logic [2*DW-1:0] s_data = '0;
    logic          m_ready = 1'b0;
    logic          m_valid;
    logic          m_sof;
    logic          m_eol;
    logic [2*DW-1:0] m_data;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;

    int n_vec = 0;
    int n_err = 0;

    dwt97_column_sequencer #(
        .DataWidth(DW),
        .MaximumSideSize(512),
        .FlushLines(FL)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .cfg_valid_i  (cfg_valid),
        .cfg_ready_o  (cfg_ready),
        .cfg_width_i  (cfg_width),
        .cfg_height_i (cfg_height),
        .s_ready_o    (s_ready),
        .s_valid_i    (s_valid),
        .s_data_i     (s_data),
        .m_ready_i    (m_ready),
        .m_valid_o    (m_valid),
        .m_sof_o      (m_sof),
        .m_eol_o      (m_eol),
        .m_data_o     (m_data),
        .busy_o       (busy),
        .frame_done_o (frame_done),
        .cfg_err_o    (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_cfg(input int w, input int h);
        cfg_valid  = 1'b1;
        cfg_width  = w[WW-1:0];
        cfg_height = h[HW-1:0];
        @(negedge clk);
        check("cfg_ready", cfg_ready, 1);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic bad_cfg(input int w, input int h);
        cfg_valid  = 1'b1;
        cfg_width  = w[WW-1:0];
        cfg_height = h[HW-1:0];
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        check("err_pulse", cfg_err, 1);
        check("err_busy", busy, 0);
        check("err_valid", m_valid, 0);
        @(posedge clk); #1;
        check("err_clear", cfg_err, 0);
    endtask

    task automatic flush_frame(input int w, input bit toggle);
        int k = 0;
        int cyc = 0;
        while (k < FL * w && cyc < 4000) begin
            m_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            s_valid = 1'b1;
            @(negedge clk);
            check("fl_valid", m_valid, 1);
            check("fl_sready", s_ready, 0);
            check("fl_data", m_data, 0);
            check("fl_sof", m_sof, k == 0);
            check("fl_eol", m_eol, (k % w) == w - 1);
            @(posedge clk); #1;
            if (m_ready) k++;
            cyc++;
        end
        s_valid = 1'b0;
        check("fl_beats", k, FL * w);
    endtask

    task automatic send_frame(input int w, input int h, input bit toggle);
        int k = 0;
        int cyc = 0;
        apply_cfg(w, h);
        check("busy", busy, 1);
        while (k < w * h && cyc < 4000) begin
            m_ready = toggle ? (cyc % 2 == 1) : 1'b1;
            s_valid = 1'b1;
            s_data  = 32'hD000_0000 + k;
            @(negedge clk);
            check("s_ready", s_ready, m_ready);
            check("m_valid", m_valid, 1);
            check("m_data", m_data, 32'hD000_0000 + k);
            check("m_sof", m_sof, k == 0);
            check("m_eol", m_eol, (k % w) == w - 1);
            @(posedge clk); #1;
            if (m_ready) k++;
            cyc++;
        end
        s_valid = 1'b0;
        check("beats", k, w * h);
`ifdef DWT97_SEQ_FLUSH_EN
        check("done_early", frame_done, 0);
        flush_frame(w, toggle);
`endif
        m_ready = 1'b1;
        @(negedge clk);
        check("frame_done", frame_done, 1);
        check("busy_end", busy, 0);
        @(posedge clk); #1;
        check("done_pulse", frame_done, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", m_valid, 0);
        check("rst_sready", s_ready, 0);
        check("rst_cfgrdy", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", cfg_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        send_frame(4, 2, 1'b0);
        send_frame(4, 2, 1'b1);

        bad_cfg(0, 2);
        bad_cfg(4, 1);
        bad_cfg(257, 4);
        bad_cfg(4, 513);

        send_frame(1, 3, 1'b0);

        apply_cfg(4, 2);
        m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i);
            @(posedge clk); #1;
        end
        s_data = 32'h55;
        @(negedge clk);
        check("mid_valid", m_valid, 1);
        check("mid_sof", m_sof, 0);
        check("mid_eol", m_eol, 0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", m_valid, 0);
        check("arst_cfgrdy", cfg_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_sready", s_ready, 0);
        s_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        send_frame(2, 2, 1'b0);

        apply_cfg(2, 2);
        cfg_valid  = 1'b1;
        cfg_width  = 9'd3;
        cfg_height = 10'd2;
        m_ready    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hB000 + i;
            @(negedge clk);
            check("b2b_cfgrdy", cfg_ready, 0);
            check("b2b_eol", m_eol, i % 2 == 1);
            @(posedge clk); #1;
        end
`ifdef DWT97_SEQ_FLUSH_EN
        flush_frame(2, 1'b0);
`endif
        s_valid = 1'b1;
        @(negedge clk);
        check("gap_cfgrdy", cfg_ready, 1);
        check("gap_valid", m_valid, 0);
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            s_data  = 32'hC000 + i;
            @(negedge clk);
            check("b2b_sof", m_sof, i == 0);
            check("b2b_eol2", m_eol, i % 3 == 2);
            check("b2b_data", m_data, 32'hC000 + i);
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
`ifdef DWT97_SEQ_FLUSH_EN
        flush_frame(3, 1'b0);
`endif
        @(negedge clk);
        check("b2b_done", frame_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
